fetch_decode_stage: RTL and testbench

Front end of the 4-bit-opcode pipelined core. Holds the program counter, fetches from the combinational instruction ROM, and latches each instruction into the IF/ID pipeline register. Also splits the latched word into the fields consumed downstream: `operation` and `imm` go to the control unit, register indices and immediates go to the register file and ALU. Absorbs stalls, branch redirects from execute, and a HALT opcode.

---
 rtl/cpu_pkg.sv | 42 ++++
 rtl/instr_field_decoder.sv | 35 +++
 rtl/fetch_decode_stage.sv | 107 ++++++++++
 tb/tb_fetch_decode_stage.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit-opcode core: opcodes, instruction field
// positions and the fetch state machine encoding.
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_AND  = 4'b0010,
        OP_OR   = 4'b0011,
        OP_XOR  = 4'b0100,
        OP_SHL  = 4'b0101,
        OP_SET  = 4'b0110,
        OP_LD   = 4'b0111,
        OP_ST   = 4'b1000,
        OP_B    = 4'b1001,
        OP_BEQ  = 4'b1010,
        OP_BGE  = 4'b1011,
        OP_NOP  = 4'b1100,
        OP_RSV0 = 4'b1101,
        OP_RSV1 = 4'b1110,
        OP_HALT = 4'b1111
    } opcode_e;

    localparam int OPC_HI  = 31;
    localparam int OPC_LO  = 28;
    localparam int IMM_BIT = 27;
    localparam int RD_HI   = 26;
    localparam int RD_LO   = 23;
    localparam int RS1_HI  = 22;
    localparam int RS1_LO  = 19;
    localparam int RS2_HI  = 18;
    localparam int RS2_LO  = 15;
    localparam int IMM16_HI = 15;
    localparam int BOFF_HI  = 23;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_field_decoder.sv
// Combinational split of a latched instruction word into the fields used by
// control, register file and ALU; invalid slots present as NOP.
module instr_field_decoder
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic [31:0]       word_i,
    input  logic              valid_i,
    output logic [3:0]        operation_o,
    output logic              imm_o,
    output logic [3:0]        rd_o,
    output logic [3:0]        rs1_o,
    output logic [3:0]        rs2_o,
    output logic [31:0]       immval_o,
    output logic [ADDR_W-1:0] branch_off_o
);

    assign operation_o = valid_i ? word_i[OPC_HI:OPC_LO] : OP_NOP;
    assign imm_o       = valid_i & word_i[IMM_BIT];
    assign rd_o        = word_i[RD_HI:RD_LO];
    assign rs1_o       = word_i[RS1_HI:RS1_LO];
    assign rs2_o       = word_i[RS2_HI:RS2_LO];
    assign immval_o    = {{16{word_i[IMM16_HI]}}, word_i[IMM16_HI:0]};

    // The 24-bit offset field is cut down or sign-extended to the PC width.
    generate
        if (ADDR_W <= BOFF_HI + 1) begin : g_boff_trunc
            assign branch_off_o = word_i[ADDR_W-1:0];
        end else begin : g_boff_sext
            assign branch_off_o = {{(ADDR_W-BOFF_HI-1){word_i[BOFF_HI]}}, word_i[BOFF_HI:0]};
        end
    endgenerate

endmodule

// File: rtl/fetch_decode_stage.sv
// Front end: PC, instruction fetch from a combinational ROM and the IF/ID
// register, with stall, branch redirect and HALT handling.
module fetch_decode_stage
    import cpu_pkg::*;
#(
    parameter int          ADDR_W   = 10,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic              id_valid,
    output logic [ADDR_W-1:0] id_pc,
    output logic [3:0]        id_operation,
    output logic              id_imm,
    output logic [3:0]        id_rd,
    output logic [3:0]        id_rs1,
    output logic [3:0]        id_rs2,
    output logic [31:0]       id_immval,
    output logic [ADDR_W-1:0] id_branch_off,
    output logic              halted
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       word_q, word_d;
    logic [ADDR_W-1:0] ifid_pc_q, ifid_pc_d;
    logic              valid_q, valid_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= BOOT;
            pc_q      <= RESET_PC;
            word_q    <= '0;
            ifid_pc_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            word_q    <= word_d;
            ifid_pc_q <= ifid_pc_d;
            valid_q   <= valid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        word_d    = word_q;
        ifid_pc_d = ifid_pc_q;
        valid_d   = valid_q;

        // Redirect beats stall, and stall beats everything the FSM would do.
        if (redirect_valid) begin
            pc_d      = redirect_pc;
            state_d   = RUN;
            word_d    = '0;
            ifid_pc_d = '0;
            valid_d   = 1'b0;
        end else if (!stall) begin
            case (state_q)
                RUN: begin
                    word_d    = imem_rdata;
                    ifid_pc_d = pc_q;
                    valid_d   = 1'b1;
                    if (imem_rdata[OPC_HI:OPC_LO] == OP_HALT) begin
                        state_d = HALT;
                    end else begin
                        pc_d = pc_q + 1'b1;
                    end
                end
                default: begin
                    if (state_q == BOOT) begin
                        state_d = RUN;
                    end
                    word_d    = '0;
                    ifid_pc_d = '0;
                    valid_d   = 1'b0;
                end
            endcase
        end
    end

    assign imem_addr = pc_q;
    assign id_valid  = valid_q;
    assign id_pc     = ifid_pc_q;
    assign halted    = (state_q == HALT);

    instr_field_decoder #(
        .ADDR_W(ADDR_W)
    ) u_decoder (
        .word_i      (word_q),
        .valid_i     (valid_q),
        .operation_o (id_operation),
        .imm_o       (id_imm),
        .rd_o        (id_rd),
        .rs1_o       (id_rs1),
        .rs2_o       (id_rs2),
        .immval_o    (id_immval),
        .branch_off_o(id_branch_off)
    );

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Directed bench for fetch_decode_stage: boot, decode fields, stall, redirect,
// HALT, PC wrap and asynchronous reset, each compared with hand-worked values.
module tb_fetch_decode_stage;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              stall;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic              id_valid;
    logic [ADDR_W-1:0] id_pc;
    logic [3:0]        id_operation;
    logic              id_imm;
    logic [3:0]        id_rd;
    logic [3:0]        id_rs1;
    logic [3:0]        id_rs2;
    logic [31:0]       id_immval;
    logic [ADDR_W-1:0] id_branch_off;
    logic              halted;

    logic [31:0] rom [0:(1<<ADDR_W)-1];
    int total  = 0;
    int passed = 0;

    assign imem_rdata = rom[imem_addr];

    always #5 clk = ~clk;

    fetch_decode_stage #(
        .ADDR_W  (ADDR_W),
        .RESET_PC('0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .id_valid      (id_valid),
        .id_pc         (id_pc),
        .id_operation  (id_operation),
        .id_imm        (id_imm),
        .id_rd         (id_rd),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_immval     (id_immval),
        .id_branch_off (id_branch_off),
        .halted        (halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".valid"},  32'(id_valid), 32'h0);
        chk({tag, ".op"},     32'(id_operation), 32'hC);
        chk({tag, ".imm"},    32'(id_imm), 32'h0);
        chk({tag, ".pc"},     32'(id_pc), 32'h0);
        chk({tag, ".rd"},     32'(id_rd), 32'h0);
        chk({tag, ".rs1"},    32'(id_rs1), 32'h0);
        chk({tag, ".rs2"},    32'(id_rs2), 32'h0);
        chk({tag, ".immval"}, id_immval, 32'h0);
        chk({tag, ".boff"},   32'(id_branch_off), 32'h0);
        chk({tag, ".halted"}, 32'(halted), 32'h0);
        chk({tag, ".iaddr"},  32'(imem_addr), 32'h0);
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) rom[i] = 32'hC000_0000;
        rom[0]     = 32'h0123_4567;   // ADD
        rom[1]     = 32'h1000_0000;   // SUB
        rom[2]     = 32'h6800_FFFF;   // SET imm=1, imm16=FFFF
        rom[3]     = 32'h90FF_FFFE;   // B, offset -2
        rom[4]     = 32'h029C_8000;   // ADD rd=5 rs1=3 rs2=9
        rom[5]     = 32'h1000_0005;
        rom[6]     = 32'h2000_0006;
        rom[7]     = 32'hF000_0000;   // HALT
        rom[10'h3F]  = 32'h2000_0000;
        rom[10'h3FF] = 32'h6FFF_FFFF;

        rst_n = 1'b0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        #2;
        chk_reset_outputs("reset");
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;

        step();
        chk("boot.valid", 32'(id_valid), 32'h0);
        chk("boot.op", 32'(id_operation), 32'hC);
        chk("boot.iaddr", 32'(imem_addr), 32'h0);
        step();
        chk("f0.valid", 32'(id_valid), 32'h1);
        chk("f0.pc", 32'(id_pc), 32'h0);
        chk("f0.op", 32'(id_operation), 32'h0);
        step();
        chk("f1.pc", 32'(id_pc), 32'h1);
        chk("f1.op", 32'(id_operation), 32'h1);
        step();
        chk("set.imm", 32'(id_imm), 32'h1);
        chk("set.immval", id_immval, 32'hFFFF_FFFF);
        chk("set.op", 32'(id_operation), 32'h6);
        step();
        chk("b.op", 32'(id_operation), 32'h9);
        chk("b.boff", 32'(id_branch_off), 32'h3FE);
        step();
        chk("regs.rd", 32'(id_rd), 32'h5);
        chk("regs.rs1", 32'(id_rs1), 32'h3);
        chk("regs.rs2", 32'(id_rs2), 32'h9);
        chk("regs.immval", id_immval, 32'hFFFF_8000);
        chk("regs.iaddr", 32'(imem_addr), 32'h5);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall.iaddr", 32'(imem_addr), 32'h5);
            chk("stall.pc", 32'(id_pc), 32'h4);
            chk("stall.rd", 32'(id_rd), 32'h5);
        end
        stall = 1'b0;
        step();
        chk("resume.pc", 32'(id_pc), 32'h5);
        chk("resume.iaddr", 32'(imem_addr), 32'h6);
        step();
        chk("pc6.pc", 32'(id_pc), 32'h6);
        chk("pc6.iaddr", 32'(imem_addr), 32'h7);

        step();
        chk("halt.op", 32'(id_operation), 32'hF);
        chk("halt.valid", 32'(id_valid), 32'h1);
        chk("halt.halted", 32'(halted), 32'h1);
        chk("halt.iaddr", 32'(imem_addr), 32'h7);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("halted.valid", 32'(id_valid), 32'h0);
            chk("halted.op", 32'(id_operation), 32'hC);
            chk("halted.iaddr", 32'(imem_addr), 32'h7);
            chk("halted.halted", 32'(halted), 32'h1);
        end

        stall = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 10'h3F;
        step();
        chk("redir.valid", 32'(id_valid), 32'h0);
        chk("redir.iaddr", 32'(imem_addr), 32'h3F);
        chk("redir.halted", 32'(halted), 32'h0);
        stall = 1'b0;
        redirect_valid = 1'b0;
        step();
        chk("target.valid", 32'(id_valid), 32'h1);
        chk("target.pc", 32'(id_pc), 32'h3F);
        chk("target.op", 32'(id_operation), 32'h2);

        redirect_valid = 1'b1;
        redirect_pc = 10'h3FE;
        step();
        redirect_valid = 1'b0;
        chk("wrap.bubble", 32'(id_valid), 32'h0);
        step();
        chk("wrap.pc3fe", 32'(id_pc), 32'h3FE);
        chk("wrap.iaddr3ff", 32'(imem_addr), 32'h3FF);
        step();
        chk("wrap.pc3ff", 32'(id_pc), 32'h3FF);
        chk("wrap.iaddr0", 32'(imem_addr), 32'h0);
        chk("wrap.rd", 32'(id_rd), 32'hF);

        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("reboot.valid", 32'(id_valid), 32'h0);
        step();
        chk("reboot.valid2", 32'(id_valid), 32'h1);
        chk("reboot.op", 32'(id_operation), 32'h0);
        chk("reboot.iaddr", 32'(imem_addr), 32'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
